// File: rtl/mips_cp0_timer.sv
// CP0 for the P7 MIPS pipeline: SR/Cause/EPC/PrID, exception/interrupt request
// generation and a prescaled Count/Compare timer that feeds one interrupt line.
module mips_cp0_timer #(
  parameter int          NUM_HWINT     = 6,
  parameter int          TIMER_LINE    = 5,
  parameter int          PRESCALE_LOG2 = 0,
  parameter logic [31:0] PRID_VAL      = 32'h23371323
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [4:0]           rd_addr,
  input  logic [4:0]           wr_addr,
  input  logic [31:0]          wr_data,
  input  logic                 wr_en,
  input  logic [31:0]          pc,
  input  logic                 bd,
  input  logic                 exc_valid,
  input  logic [4:0]           exc_code,
  input  logic [NUM_HWINT-1:0] hw_int,
  input  logic                 exl_clr,
  output logic                 req,
  output logic [31:0]          epc_out,
  output logic [31:0]          rd_data,
  output logic                 timer_irq
);

  localparam logic [7:0] PRESC_MAX = 8'((32'd1 << PRESCALE_LOG2) - 32'd1);

  logic [31:0]          sr_q, sr_d, cause_q, cause_d, epc_q, epc_d;
  logic [31:0]          count_q, count_d, compare_q, compare_d;
  logic [7:0]           presc_q, presc_d;
  logic                 timer_irq_q, timer_irq_d;
  logic [NUM_HWINT-1:0] pend;
  logic                 int_req, exc_req, wrap, count_wr, cmp_wr;
  logic [31:0]          epc_next, count_inc;

  always_comb begin
    pend             = hw_int;
    pend[TIMER_LINE] = hw_int[TIMER_LINE] | timer_irq_q;
  end

  assign int_req   = (|(pend & sr_q[10 +: NUM_HWINT])) & ~sr_q[1] & sr_q[0];
  assign exc_req   = exc_valid & ~sr_q[1];
  assign req       = int_req | exc_req;
  assign epc_next  = bd ? (pc - 32'd4) : pc;
  assign epc_out   = req ? epc_next : epc_q;
  assign timer_irq = timer_irq_q;

  // A taken request swallows any mtc0 issued alongside it.
  assign count_wr  = ~req & wr_en & (wr_addr == 5'd9);
  assign cmp_wr    = ~req & wr_en & (wr_addr == 5'd11);
  assign wrap      = (presc_q == PRESC_MAX);
  assign count_inc = count_q + 32'd1;

  always_comb begin
    sr_d    = sr_q;
    epc_d   = epc_q;
    cause_d = cause_q;
    if (req) begin
      sr_d[1]       = 1'b1;
      epc_d         = epc_next;
      cause_d[31]   = bd;
      cause_d[6:2]  = int_req ? 5'd0 : exc_code;
    end else begin
      if (wr_en && wr_addr == 5'd12) sr_d  = wr_data;
      if (wr_en && wr_addr == 5'd14) epc_d = {wr_data[31:2], 2'b00};
      if (exl_clr)                   sr_d[1] = 1'b0;
    end
    cause_d[10 +: NUM_HWINT] = pend;
    cause_d[30]              = timer_irq_q;
  end

  // Timer keeps running regardless of EXL; a Count write restarts the prescaler
  // and never raises the interrupt by itself.
  always_comb begin
    count_d     = count_q;
    compare_d   = compare_q;
    presc_d     = wrap ? 8'd0 : presc_q + 8'd1;
    timer_irq_d = timer_irq_q;
    if (count_wr) begin
      count_d = wr_data;
      presc_d = 8'd0;
    end else if (wrap) begin
      count_d = count_inc;
      if (count_inc == compare_q) timer_irq_d = 1'b1;
    end
    if (cmp_wr) begin
      compare_d   = wr_data;
      timer_irq_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr_q        <= '0;
      cause_q     <= '0;
      epc_q       <= '0;
      count_q     <= '0;
      compare_q   <= 32'hFFFF_FFFF;
      presc_q     <= '0;
      timer_irq_q <= 1'b0;
    end else begin
      sr_q        <= sr_d;
      cause_q     <= cause_d;
      epc_q       <= epc_d;
      count_q     <= count_d;
      compare_q   <= compare_d;
      presc_q     <= presc_d;
      timer_irq_q <= timer_irq_d;
    end
  end

  always_comb begin
    case (rd_addr)
      5'd9:    rd_data = count_q;
      5'd11:   rd_data = compare_q;
      5'd12:   rd_data = sr_q;
      5'd13:   rd_data = cause_q;
      5'd14:   rd_data = epc_out;
      5'd15:   rd_data = PRID_VAL;
      default: rd_data = 32'd0;
    endcase
  end

endmodule
